// File: rtl/axi_wr_pkg.sv
// axi_wr_pkg: shared encodings and FSM state type for the AXI write slave.
package axi_wr_pkg;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {IDLE, DATA, RESP} wr_state_t;
endpackage

// File: rtl/axi_wr_beat_fifo.sv
// axi_wr_beat_fifo: synchronous FIFO with extra pointer bit to separate full from empty.
module axi_wr_beat_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign dout  = mem[rd_ptr[PW-1:0]];
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[PW-1:0]] <= din;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end
endmodule

// File: rtl/axi_wr_slave_fifo.sv
// axi_wr_slave_fifo: single-burst AXI4 write slave buffering beats for a downstream memory port.
// Define AXI_WR_WRAP_EN to support WRAP bursts; otherwise WRAP is answered with SLVERR.
module axi_wr_slave_fifo
    import axi_wr_pkg::*;
#(
    parameter int ID_W       = 6,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_data,
    output logic [DATA_W/8-1:0] mem_strb,
    output logic                mem_valid,
    input  logic                mem_ready
);
    localparam int SW = DATA_W/8;
    localparam int EW = ADDR_W + DATA_W + SW;
    localparam logic [2:0] SIZE_MAX = 3'($clog2(SW));

    wr_state_t state;
    logic [ID_W-1:0] id_r;
    logic [ADDR_W-1:0] addr_r, step, next_addr;
    logic [7:0] len_r, cnt;
    logic [2:0] size_r;
    logic [1:0] burst_r;
    logic err, aw_err, wrap_err, beat, last_beat, beat_err, fifo_full, fifo_empty;
    logic [EW-1:0] head;

`ifdef AXI_WR_WRAP_EN
    logic [ADDR_W-1:0] wrap_mask;
    assign wrap_err  = awburst == BURST_WRAP &&
                       (!(awlen inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                        (awaddr & ((ADDR_W'(1) << awsize) - ADDR_W'(1))) != '0);
    assign wrap_mask = ((ADDR_W'(len_r) + ADDR_W'(1)) << size_r) - ADDR_W'(1);
    assign next_addr = burst_r == BURST_FIXED ? addr_r :
                       burst_r == BURST_WRAP  ? (addr_r & ~wrap_mask) | ((addr_r + step) & wrap_mask) :
                                                addr_r + step;
`else
    assign wrap_err  = awburst == BURST_WRAP;
    assign next_addr = burst_r == BURST_FIXED ? addr_r : addr_r + step;
`endif

    assign aw_err    = awsize > SIZE_MAX || awburst == 2'b11 || wrap_err;
    assign step      = ADDR_W'(1) << size_r;
    assign wready    = state == DATA && !fifo_full;
    assign beat      = wvalid && wready;
    assign last_beat = cnt == len_r;
    // A wlast that disagrees with the beat count is a protocol error either way.
    assign beat_err  = wlast != last_beat;
    assign mem_valid = !fifo_empty;
    assign {mem_addr, mem_data, mem_strb} = head;

    axi_wr_beat_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (beat && !err),
        .din   ({addr_r, wdata, wstrb}),
        .pop   (mem_valid && mem_ready),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            awready <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            bid     <= '0;
            id_r    <= '0;
            addr_r  <= '0;
            len_r   <= '0;
            size_r  <= '0;
            burst_r <= '0;
            cnt     <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (awvalid && awready) begin
                        awready <= 1'b0;
                        id_r    <= awid;
                        addr_r  <= awaddr;
                        len_r   <= awlen;
                        size_r  <= awsize;
                        burst_r <= awburst;
                        cnt     <= '0;
                        err     <= aw_err;
                        state   <= DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                DATA: begin
                    if (beat) begin
                        cnt    <= cnt + 8'd1;
                        addr_r <= next_addr;
                        if (beat_err) err <= 1'b1;
                        if (wlast || last_beat) begin
                            state  <= RESP;
                            bvalid <= 1'b1;
                            bid    <= id_r;
                            bresp  <= (err || beat_err) ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_wr_slave_fifo.sv
// tb_axi_wr_slave_fifo: directed bursts with a scoreboard monitor on the memory and B ports.
module tb_axi_wr_slave_fifo;
    import axi_wr_pkg::*;
    localparam int ID_W = 6, ADDR_W = 32, DATA_W = 32, SW = 4, DEPTH = 4;

    logic clk = 1'b0, reset;
    logic [ID_W-1:0] awid, bid;
    logic [ADDR_W-1:0] awaddr, mem_addr;
    logic [7:0] awlen;
    logic [2:0] awsize;
    logic [1:0] awburst, bresp;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready, mem_valid, mem_ready;
    logic [DATA_W-1:0] wdata, mem_data;
    logic [SW-1:0] wstrb, mem_strb;

    axi_wr_slave_fifo #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_strb(mem_strb),
        .mem_valid(mem_valid), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] s;} beat_t;
    beat_t exp_mem[$];
    logic [7:0] exp_b[$];
    logic [31:0] ea [8];
    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        beat_t e;
        logic [7:0] b;
        if (!reset && mem_valid && mem_ready) begin
            if (exp_mem.size() == 0) begin
                tests++; fails++;
                $display("FAIL mem_extra: got %0h expected no beat", {mem_addr, mem_data, mem_strb});
            end else begin
                e = exp_mem.pop_front();
                check("mem_beat", {mem_addr, mem_data, mem_strb}, e);
            end
        end
        if (!reset && bvalid && bready) begin
            if (exp_b.size() == 0) begin
                tests++; fails++;
                $display("FAIL b_extra: got %0h expected no response", {bid, bresp});
            end else begin
                b = exp_b.pop_front();
                check("b_resp", {bid, bresp}, b);
            end
        end
    end

    // All drive tasks are entered just after a rising edge.
    task automatic send_aw(input logic [5:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        @(negedge clk);
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (!awready) begin tests++; fails++; $display("FAIL aw_timeout: got awready 0 expected 1"); end
        @(posedge clk); #1 awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n = 0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        @(negedge clk);
        while (!wready && n < 50) begin @(negedge clk); n++; end
        if (!wready) begin tests++; fails++; $display("FAIL w_timeout: got wready 0 expected 1"); end
        @(posedge clk); #1 wvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_mem.size() != 0 || exp_b.size() != 0) && n < 100) begin @(negedge clk); n++; end
        if (n == 100) begin tests++; fails++; $display("FAIL drain_timeout: got %0d pending expected 0", exp_mem.size() + exp_b.size()); end
        @(posedge clk); #1;
    endtask

    task automatic run_burst(input logic [5:0] id, input logic [31:0] a, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int nb,
                             input int last_at, input int npush, input logic [1:0] resp);
        logic [31:0] d;
        logic [3:0] s;
        exp_b.push_back({id, resp});
        send_aw(id, a, len, size, burst);
        for (int i = 0; i < nb; i++) begin
            d = {a[15:0], 16'(i)};
            s = 4'(i + 1);
            if (i < npush) exp_mem.push_back({ea[i], d, s});
            send_w(d, s, i == last_at);
        end
        @(negedge clk);
        check("b_latency", 72'(bvalid), 72'(1));
        wait_drain();
    endtask

    initial begin
        reset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b1; mem_ready = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; wdata = '0; wstrb = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 72'(awready), 72'(0));
        check("rst_wready", 72'(wready), 72'(0));
        check("rst_bvalid", 72'(bvalid), 72'(0));
        check("rst_bresp", 72'(bresp), 72'(0));
        check("rst_bid", 72'(bid), 72'(0));
        check("rst_mem_valid", 72'(mem_valid), 72'(0));
        @(posedge clk); #1 reset = 1'b0;

        ea = '{32'h100, 32'h104, 32'h108, 32'h10C, 0, 0, 0, 0};
        run_burst(6'h2A, 32'h100, 8'd3, 3'd2, BURST_INCR, 4, 3, 4, RESP_OKAY);

        // Backpressure: a 4-deep FIFO fills and stalls the W channel.
        mem_ready = 1'b0;
        ea = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h210, 32'h214, 32'h218, 32'h21C};
        exp_b.push_back({6'h11, RESP_OKAY});
        send_aw(6'h11, 32'h200, 8'd7, 3'd2, BURST_INCR);
        for (int i = 0; i < 4; i++) begin
            exp_mem.push_back({ea[i], 16'h0200, 16'(i), 4'(i + 1)});
            send_w({16'h0200, 16'(i)}, 4'(i + 1), 1'b0);
        end
        @(negedge clk);
        check("wready_full", 72'(wready), 72'(0));
        check("mem_valid_full", 72'(mem_valid), 72'(1));
        @(posedge clk); #1 mem_ready = 1'b1;
        for (int i = 4; i < 8; i++) begin
            exp_mem.push_back({ea[i], 16'h0200, 16'(i), 4'(i + 1)});
            send_w({16'h0200, 16'(i)}, 4'(i + 1), i == 7);
        end
        @(negedge clk);
        check("b_latency", 72'(bvalid), 72'(1));
        wait_drain();

        ea = '{32'h300, 32'h304, 0, 0, 0, 0, 0, 0};
        run_burst(6'h05, 32'h300, 8'd3, 3'd2, BURST_INCR, 2, 1, 2, RESP_SLVERR);
        run_burst(6'h07, 32'h400, 8'd1, 3'd3, BURST_INCR, 2, 1, 0, RESP_SLVERR);
`ifdef AXI_WR_WRAP_EN
        ea = '{32'h38, 32'h3C, 32'h30, 32'h34, 0, 0, 0, 0};
        run_burst(6'h09, 32'h38, 8'd3, 3'd2, BURST_WRAP, 4, 3, 4, RESP_OKAY);
`else
        run_burst(6'h09, 32'h38, 8'd3, 3'd2, BURST_WRAP, 4, 3, 0, RESP_SLVERR);
`endif
        ea = '{32'h80, 32'h80, 0, 0, 0, 0, 0, 0};
        run_burst(6'h0A, 32'h80, 8'd1, 3'd2, BURST_FIXED, 2, 1, 2, RESP_OKAY);
        ea = '{32'h500, 32'h504, 0, 0, 0, 0, 0, 0};
        run_burst(6'h0B, 32'h500, 8'd1, 3'd2, BURST_INCR, 2, -1, 2, RESP_SLVERR);
        run_burst(6'h0C, 32'h600, 8'd1, 3'd2, 2'b11, 2, 1, 0, RESP_SLVERR);

        // Reset mid-burst discards buffered beats and the pending response.
        mem_ready = 1'b0;
        send_aw(6'h0D, 32'h700, 8'd3, 3'd2, BURST_INCR);
        send_w(32'h0700_0000, 4'hF, 1'b0);
        send_w(32'h0700_0001, 4'hF, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_wready", 72'(wready), 72'(0));
        check("mid_rst_bvalid", 72'(bvalid), 72'(0));
        check("mid_rst_mem_valid", 72'(mem_valid), 72'(0));
        @(posedge clk); #1 mem_ready = 1'b1;
        ea = '{32'h800, 32'h804, 32'h808, 32'h80C, 0, 0, 0, 0};
        run_burst(6'h0E, 32'h800, 8'd3, 3'd2, BURST_INCR, 4, 3, 4, RESP_OKAY);

        check("queues_empty", 72'(exp_mem.size() + exp_b.size()), 72'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
